// File: rtl/jump_issue_ctrl.sv
// Branch/jump issue controller: accepts one op, drives the jump FU, resolves
// the prediction, requests writeback of the link PC and keeps op statistics.
module jump_issue_ctrl #(
  parameter int unsigned WD_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        issue_jump,
  input  logic [4:0]  issue_rd,
  input  logic        issue_pred,
  output logic        fu_en,
  input  logic        fu_finish,
  input  logic        fu_cmp_res,
  input  logic [31:0] fu_pc_jump,
  input  logic [31:0] fu_pc_wb,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        wb_req,
  input  logic        wb_grant,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        flush,
  output logic        busy,
  output logic        wd_err,
  output logic [15:0] jump_cnt,
  output logic [15:0] mispred_cnt
);

  localparam int unsigned WD_W    = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned RD_W    = 5;

  typedef enum logic [2:0] {IDLE, EXEC, WAIT, RESOLVE, WB} state_t;

  state_t            state;
  state_t            next_state;
  logic              jump_q;
  logic              pred_q;
  logic              cmp_q;
  logic [RD_W-1:0]   rd_q;
  logic [PC_W-1:0]   pc_jump_q;
  logic [PC_W-1:0]   pc_wb_q;
  logic [WD_W-1:0]   wd_cnt;
  logic              accept_c;
  logic              wd_expire_c;
  logic              taken_c;
  logic              mispredict_c;
  logic              resolve_c;

  assign accept_c     = (state == IDLE) & issue_valid & ~flush;
  assign wd_expire_c  = (state == WAIT) & ~fu_finish & (wd_cnt == WD_W'(WD_LIMIT - 1));
  assign taken_c      = jump_q | cmp_q;
  assign mispredict_c = taken_c != pred_q;
  assign resolve_c    = (state == RESOLVE) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_c) next_state = EXEC;
      EXEC:    next_state = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)            next_state = IDLE;
        else if (fu_finish)   next_state = RESOLVE;
        else if (wd_expire_c) next_state = IDLE;
      end
      RESOLVE: begin
        if (!flush && jump_q && (rd_q != '0)) next_state = WB;
        else                                  next_state = IDLE;
      end
      WB:      if (flush || wb_grant) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are decoded from state so a cancelling flush or reset acts in the same cycle.
  always_comb begin
    issue_ready    = 1'b0;
    fu_en          = 1'b0;
    redirect_valid = 1'b0;
    wb_req         = 1'b0;
    redirect_pc    = taken_c ? pc_jump_q : pc_wb_q;
    wb_rd          = rd_q;
    wb_data        = pc_wb_q;
    busy           = state != IDLE;
    if (!rst) begin
      issue_ready    = (state == IDLE) & ~flush;
      fu_en          = state == EXEC;
      redirect_valid = resolve_c & mispredict_c;
      wb_req         = (state == WB) & ~flush;
    end
  end

  // Latched op fields, FU results, watchdog and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_q      <= 1'b0;
      pred_q      <= 1'b0;
      cmp_q       <= 1'b0;
      rd_q        <= '0;
      pc_jump_q   <= '0;
      pc_wb_q     <= '0;
      wd_cnt      <= '0;
      wd_err      <= 1'b0;
      jump_cnt    <= '0;
      mispred_cnt <= '0;
    end else begin
      if (accept_c) begin
        jump_q <= issue_jump;
        rd_q   <= issue_rd;
        pred_q <= issue_pred;
      end
      if ((state == WAIT) && !flush && fu_finish) begin
        cmp_q     <= fu_cmp_res;
        pc_jump_q <= fu_pc_jump;
        pc_wb_q   <= fu_pc_wb;
      end
      if ((state != WAIT) || flush || fu_finish || wd_expire_c) wd_cnt <= '0;
      else                                                      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_expire_c && !flush) wd_err <= 1'b1;
      if (resolve_c) begin
        if (jump_cnt != {CNT_W{1'b1}}) jump_cnt <= jump_cnt + CNT_W'(1);
        if (mispredict_c && (mispred_cnt != {CNT_W{1'b1}})) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jump_issue_ctrl.sv
// Directed self-checking bench for jump_issue_ctrl: one task per scenario,
// inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_jump_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_jump, issue_pred;
  logic [4:0]  issue_rd;
  logic        fu_en, fu_finish, fu_cmp_res;
  logic [31:0] fu_pc_jump, fu_pc_wb;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wb_req, wb_grant;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, busy, wd_err;
  logic [15:0] jump_cnt, mispred_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  jump_issue_ctrl #(.WD_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_jump(issue_jump),
    .issue_rd(issue_rd), .issue_pred(issue_pred),
    .fu_en(fu_en), .fu_finish(fu_finish), .fu_cmp_res(fu_cmp_res),
    .fu_pc_jump(fu_pc_jump), .fu_pc_wb(fu_pc_wb),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_req(wb_req), .wb_grant(wb_grant), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .busy(busy), .wd_err(wd_err),
    .jump_cnt(jump_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic idle_in();
    issue_valid = 1'b0; issue_jump = 1'b0; issue_rd = 5'd0; issue_pred = 1'b0;
    fu_finish = 1'b0; fu_cmp_res = 1'b0; fu_pc_jump = 32'd0; fu_pc_wb = 32'd0;
    wb_grant = 1'b0; flush = 1'b0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic offer(input logic j, input logic [4:0] rd, input logic p);
    issue_valid = 1'b1; issue_jump = j; issue_rd = rd; issue_pred = p;
  endtask

  task automatic finish_with(input logic cmp, input logic [31:0] pj, input logic [31:0] pw);
    fu_finish = 1'b1; fu_cmp_res = cmp; fu_pc_jump = pj; fu_pc_wb = pw;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    next_cyc();
    issue_valid = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b0) $display("FAIL reset_ready got %0h exp 0", issue_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0h exp 0", busy); else passed++;
    checks++; if (fu_en !== 1'b0) $display("FAIL reset_fu_en got %0h exp 0", fu_en); else passed++;
    checks++; if (wb_req !== 1'b0) $display("FAIL reset_wb_req got %0h exp 0", wb_req); else passed++;
    checks++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect got %0h exp 0", redirect_valid); else passed++;
    checks++; if (wd_err !== 1'b0) $display("FAIL reset_wd_err got %0h exp 0", wd_err); else passed++;
    checks++; if (jump_cnt !== 16'd0) $display("FAIL reset_jump_cnt got %0h exp 0", jump_cnt); else passed++;
    checks++; if (mispred_cnt !== 16'd0) $display("FAIL reset_mispred_cnt got %0h exp 0", mispred_cnt); else passed++;
    next_cyc();
    idle_in();
    rst = 1'b0;
  endtask

  // Not-taken prediction, branch taken to 0x100.
  task automatic test_branch_mispredict();
    do_reset();
    offer(1'b0, 5'd3, 1'b0);
    #1;
    checks++; if (issue_ready !== 1'b1) $display("FAIL bm_ready got %0h exp 1", issue_ready); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (fu_en !== 1'b1) $display("FAIL bm_fu_en got %0h exp 1", fu_en); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL bm_busy got %0h exp 1", busy); else passed++;
    next_cyc(); finish_with(1'b1, 32'h100, 32'h8); #1;
    checks++; if (fu_en !== 1'b0) $display("FAIL bm_fu_en_wait got %0h exp 0", fu_en); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (redirect_valid !== 1'b1) $display("FAIL bm_redirect got %0h exp 1", redirect_valid); else passed++;
    checks++; if (redirect_pc !== 32'h100) $display("FAIL bm_redirect_pc got %0h exp 100", redirect_pc); else passed++;
    checks++; if (wb_req !== 1'b0) $display("FAIL bm_wb_req got %0h exp 0", wb_req); else passed++;
    next_cyc(); #1;
    checks++; if (redirect_valid !== 1'b0) $display("FAIL bm_redirect_off got %0h exp 0", redirect_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL bm_idle got %0h exp 0", busy); else passed++;
    checks++; if (issue_ready !== 1'b1) $display("FAIL bm_ready_again got %0h exp 1", issue_ready); else passed++;
    checks++; if (mispred_cnt !== 16'd1) $display("FAIL bm_mispred_cnt got %0h exp 1", mispred_cnt); else passed++;
    checks++; if (jump_cnt !== 16'd1) $display("FAIL bm_jump_cnt got %0h exp 1", jump_cnt); else passed++;
  endtask

  // JAL rd=5 correctly predicted; grant arrives on the third WB cycle.
  task automatic test_jal_wb();
    do_reset();
    offer(1'b1, 5'd5, 1'b1);
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b0, 32'h80, 32'h44);
    next_cyc(); idle_in(); wb_grant = 1'b1; #1;
    checks++; if (redirect_valid !== 1'b0) $display("FAIL jal_redirect got %0h exp 0", redirect_valid); else passed++;
    checks++; if (wb_req !== 1'b0) $display("FAIL jal_wb_req_resolve got %0h exp 0", wb_req); else passed++;
    for (int i = 0; i < 3; i++) begin
      next_cyc(); wb_grant = (i == 2); #1;
      checks++; if (wb_req !== 1'b1) $display("FAIL jal_wb_req[%0d] got %0h exp 1", i, wb_req); else passed++;
      checks++; if (wb_rd !== 5'd5) $display("FAIL jal_wb_rd[%0d] got %0h exp 5", i, wb_rd); else passed++;
      checks++; if (wb_data !== 32'h44) $display("FAIL jal_wb_data[%0d] got %0h exp 44", i, wb_data); else passed++;
    end
    next_cyc(); idle_in(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL jal_busy_after got %0h exp 0", busy); else passed++;
    checks++; if (wb_req !== 1'b0) $display("FAIL jal_wb_req_after got %0h exp 0", wb_req); else passed++;
    checks++; if (jump_cnt !== 16'd1) $display("FAIL jal_jump_cnt got %0h exp 1", jump_cnt); else passed++;
    checks++; if (mispred_cnt !== 16'd0) $display("FAIL jal_mispred_cnt got %0h exp 0", mispred_cnt); else passed++;
  endtask

  // Predicted taken, falls through to pc_wb.
  task automatic test_taken_mispredict();
    do_reset();
    offer(1'b0, 5'd1, 1'b1);
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b0, 32'h300, 32'h208);
    next_cyc(); idle_in(); #1;
    checks++; if (redirect_valid !== 1'b1) $display("FAIL tm_redirect got %0h exp 1", redirect_valid); else passed++;
    checks++; if (redirect_pc !== 32'h208) $display("FAIL tm_redirect_pc got %0h exp 208", redirect_pc); else passed++;
    next_cyc(); #1;
    checks++; if (jump_cnt !== 16'd1) $display("FAIL tm_jump_cnt got %0h exp 1", jump_cnt); else passed++;
    checks++; if (mispred_cnt !== 16'd1) $display("FAIL tm_mispred_cnt got %0h exp 1", mispred_cnt); else passed++;
  endtask

  task automatic test_watchdog();
    do_reset();
    offer(1'b0, 5'd2, 1'b0);
    next_cyc(); idle_in();
    for (int i = 0; i < 4; i++) begin
      next_cyc(); #1;
      checks++; if (busy !== 1'b1) $display("FAIL wd_busy[%0d] got %0h exp 1", i, busy); else passed++;
      checks++; if (wd_err !== 1'b0) $display("FAIL wd_err_early[%0d] got %0h exp 0", i, wd_err); else passed++;
    end
    next_cyc(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL wd_idle got %0h exp 0", busy); else passed++;
    checks++; if (wd_err !== 1'b1) $display("FAIL wd_err got %0h exp 1", wd_err); else passed++;
    checks++; if (redirect_valid !== 1'b0) $display("FAIL wd_redirect got %0h exp 0", redirect_valid); else passed++;
    checks++; if (jump_cnt !== 16'd0) $display("FAIL wd_jump_cnt got %0h exp 0", jump_cnt); else passed++;
    checks++; if (issue_ready !== 1'b1) $display("FAIL wd_ready got %0h exp 1", issue_ready); else passed++;
    // Next op: finish arrives on the last permitted WAIT cycle and must be honoured.
    offer(1'b0, 5'd2, 1'b0);
    next_cyc(); idle_in(); #1;
    checks++; if (fu_en !== 1'b1) $display("FAIL wd_next_fu_en got %0h exp 1", fu_en); else passed++;
    for (int i = 0; i < 3; i++) next_cyc();
    next_cyc(); finish_with(1'b1, 32'h40, 32'h4);
    next_cyc(); idle_in(); #1;
    checks++; if (redirect_valid !== 1'b1) $display("FAIL wd_late_redirect got %0h exp 1", redirect_valid); else passed++;
    checks++; if (redirect_pc !== 32'h40) $display("FAIL wd_late_pc got %0h exp 40", redirect_pc); else passed++;
    next_cyc(); #1;
    checks++; if (jump_cnt !== 16'd1) $display("FAIL wd_late_jump_cnt got %0h exp 1", jump_cnt); else passed++;
    checks++; if (wd_err !== 1'b1) $display("FAIL wd_err_sticky got %0h exp 1", wd_err); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    flush = 1'b1; issue_valid = 1'b1; #1;
    checks++; if (issue_ready !== 1'b0) $display("FAIL fl_idle_ready got %0h exp 0", issue_ready); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL fl_idle_blocked got %0h exp 0", busy); else passed++;
    // Flush in EXEC: FU still enabled this cycle; stale finish in IDLE ignored.
    offer(1'b1, 5'd4, 1'b0);
    next_cyc(); idle_in(); flush = 1'b1; #1;
    checks++; if (fu_en !== 1'b1) $display("FAIL fl_exec_fu_en got %0h exp 1", fu_en); else passed++;
    next_cyc(); idle_in(); finish_with(1'b1, 32'h500, 32'h504); #1;
    checks++; if (busy !== 1'b0) $display("FAIL fl_exec_idle got %0h exp 0", busy); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL fl_exec_stale got %0h exp 0", busy); else passed++;
    // Flush in WAIT followed by a stale finish.
    offer(1'b0, 5'd4, 1'b0);
    next_cyc(); idle_in();
    next_cyc(); flush = 1'b1; #1;
    checks++; if (issue_ready !== 1'b0) $display("FAIL fl_wait_ready got %0h exp 0", issue_ready); else passed++;
    next_cyc(); flush = 1'b0; finish_with(1'b1, 32'h500, 32'h504); #1;
    checks++; if (busy !== 1'b0) $display("FAIL fl_wait_idle got %0h exp 0", busy); else passed++;
    checks++; if (issue_ready !== 1'b1) $display("FAIL fl_wait_ready_after got %0h exp 1", issue_ready); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (redirect_valid !== 1'b0) $display("FAIL fl_wait_redirect got %0h exp 0", redirect_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL fl_wait_stale got %0h exp 0", busy); else passed++;
    // Flush in RESOLVE cancels redirect and counters.
    offer(1'b0, 5'd4, 1'b0);
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b1, 32'h500, 32'h504);
    next_cyc(); idle_in(); flush = 1'b1; #1;
    checks++; if (redirect_valid !== 1'b0) $display("FAIL fl_res_redirect got %0h exp 0", redirect_valid); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (jump_cnt !== 16'd0) $display("FAIL fl_jump_cnt got %0h exp 0", jump_cnt); else passed++;
    checks++; if (mispred_cnt !== 16'd0) $display("FAIL fl_mispred_cnt got %0h exp 0", mispred_cnt); else passed++;
  endtask

  task automatic test_flush_grant();
    do_reset();
    offer(1'b1, 5'd7, 1'b0);
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b0, 32'h600, 32'h604);
    next_cyc(); idle_in(); #1;
    checks++; if (redirect_pc !== 32'h600) $display("FAIL fg_redirect_pc got %0h exp 600", redirect_pc); else passed++;
    next_cyc(); flush = 1'b1; wb_grant = 1'b1; #1;
    checks++; if (wb_req !== 1'b0) $display("FAIL fg_wb_req got %0h exp 0", wb_req); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL fg_busy got %0h exp 0", busy); else passed++;
    checks++; if (jump_cnt !== 16'd1) $display("FAIL fg_jump_cnt got %0h exp 1", jump_cnt); else passed++;
  endtask

  // JAL to x0 skips WB; back-to-back JAL with a first-cycle grant.
  task automatic test_back_to_back();
    do_reset();
    offer(1'b1, 5'd0, 1'b1);
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b0, 32'h0, 32'h10);
    next_cyc(); idle_in();
    next_cyc(); offer(1'b1, 5'd9, 1'b1); #1;
    checks++; if (busy !== 1'b0) $display("FAIL bb_rd0_no_wb got %0h exp 0", busy); else passed++;
    checks++; if (issue_ready !== 1'b1) $display("FAIL bb_ready got %0h exp 1", issue_ready); else passed++;
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b0, 32'h0, 32'h20);
    next_cyc(); idle_in();
    next_cyc(); wb_grant = 1'b1; #1;
    checks++; if (wb_req !== 1'b1) $display("FAIL bb_wb_req got %0h exp 1", wb_req); else passed++;
    checks++; if (wb_data !== 32'h20) $display("FAIL bb_wb_data got %0h exp 20", wb_data); else passed++;
    checks++; if (wb_rd !== 5'd9) $display("FAIL bb_wb_rd got %0h exp 9", wb_rd); else passed++;
    next_cyc(); idle_in(); #1;
    checks++; if (busy !== 1'b0) $display("FAIL bb_one_cycle_wb got %0h exp 0", busy); else passed++;
    checks++; if (jump_cnt !== 16'd2) $display("FAIL bb_jump_cnt got %0h exp 2", jump_cnt); else passed++;
  endtask

  // Counter preloaded one below saturation, then asynchronous reset during WB.
  task automatic test_saturation_and_reset();
    do_reset();
    dut.jump_cnt = 16'hFFFE;
    offer(1'b0, 5'd1, 1'b0);
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b0, 32'h0, 32'h60);
    next_cyc(); idle_in();
    next_cyc(); #1;
    checks++; if (jump_cnt !== 16'hFFFF) $display("FAIL sat_reach got %0h exp ffff", jump_cnt); else passed++;
    offer(1'b1, 5'd2, 1'b1);
    next_cyc(); idle_in();
    next_cyc(); finish_with(1'b0, 32'h0, 32'h70);
    next_cyc(); idle_in();
    next_cyc(); #1;
    checks++; if (jump_cnt !== 16'hFFFF) $display("FAIL sat_hold got %0h exp ffff", jump_cnt); else passed++;
    checks++; if (wb_req !== 1'b1) $display("FAIL rst_pre_wb_req got %0h exp 1", wb_req); else passed++;
    #1 rst = 1'b1;
    #1;
    checks++; if (wb_req !== 1'b0) $display("FAIL rst_wb_req got %0h exp 0", wb_req); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0h exp 0", busy); else passed++;
    checks++; if (jump_cnt !== 16'd0) $display("FAIL rst_jump_cnt got %0h exp 0", jump_cnt); else passed++;
    next_cyc(); rst = 1'b0; #1;
    checks++; if (wb_req !== 1'b0) $display("FAIL rst_after_wb_req got %0h exp 0", wb_req); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_branch_mispredict();
    test_jal_wb();
    test_taken_mispredict();
    test_watchdog();
    test_flush();
    test_flush_grant();
    test_back_to_back();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/jump_issue_ctrl.md
JUMP_ISSUE_CTRL -- requirements
Module: jump_issue_ctrl

Interface
REQ-001 The block SHALL have parameter WD_LIMIT, default 4: the maximum number of WAIT cycles spent waiting for fu_finish.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset; asynchronous, active-high.
REQ-004 Port issue_valid, input, 1: a branch/jump op is offered.
REQ-005 Port issue_ready, output, 1: the controller accepts the offered op.
REQ-006 Port issue_jump, input, 1: 1 = JAL/JALR (unconditional, writes rd); 0 = conditional branch.
REQ-007 Port issue_rd, input, 5: destination register.
REQ-008 Port issue_pred, input, 1: predicted-taken bit.
REQ-009 Port fu_en, output, 1: enable to the jump functional unit.
REQ-010 Port fu_finish, input, 1: FU result-valid pulse.
REQ-011 Port fu_cmp_res, input, 1: FU compare result.
REQ-012 Port fu_pc_jump, input, 32: FU target PC.
REQ-013 Port fu_pc_wb, input, 32: FU link PC (PC+4).
REQ-014 Port redirect_valid, output, 1: one-cycle fetch redirect pulse.
REQ-015 Port redirect_pc, output, 32: redirect target.
REQ-016 Port wb_req, output, 1: request to the writeback arbiter.
REQ-017 Port wb_grant, input, 1: writeback arbiter grant.
REQ-018 Port wb_rd, output, 5: writeback register.
REQ-019 Port wb_data, output, 32: writeback data.
REQ-020 Port flush, input, 1: abandon the in-flight op.
REQ-021 Port busy, output, 1: high whenever state is not IDLE.
REQ-022 Port wd_err, output, 1: sticky watchdog error.
REQ-023 Port jump_cnt, output, 16: count of completed ops, saturating.
REQ-024 Port mispred_cnt, output, 16: count of mispredicts, saturating.

Function
REQ-025 The state machine SHALL have states IDLE, EXEC, WAIT, RESOLVE and WB.
REQ-026 issue_ready SHALL equal (state==IDLE) & ~flush; an op is accepted when issue_valid & issue_ready, and on acceptance issue_jump, issue_rd and issue_pred SHALL be latched and the state SHALL become EXEC.
REQ-027 In EXEC, fu_en SHALL be 1 for exactly that one cycle, and the state SHALL become WAIT.
REQ-028 fu_en SHALL be 0 in every other state.
REQ-029 In WAIT with fu_finish=1, the block SHALL capture fu_cmp_res, fu_pc_jump and fu_pc_wb, and the state SHALL become RESOLVE.
REQ-030 In WAIT, a cycle counter SHALL count cycles without fu_finish; on reaching WD_LIMIT the block SHALL set wd_err, go to IDLE, and produce no redirect, no writeback and no counter update.
REQ-031 In RESOLVE, taken SHALL be computed as issue_jump | cmp_res, and mispredict as taken != pred.
REQ-032 In RESOLVE, redirect_valid SHALL be 1 for one cycle iff mispredict, with redirect_pc = taken ? pc_jump : pc_wb.
REQ-033 In RESOLVE, jump_cnt SHALL increment, and mispred_cnt SHALL increment iff mispredict; both SHALL saturate at 0xFFFF.
REQ-034 From RESOLVE, the next state SHALL be WB if issue_jump & rd!=0, else IDLE.
REQ-035 In WB, wb_req SHALL be 1 with wb_rd = rd and wb_data = pc_wb, held stable until wb_grant; when wb_grant=1 the state SHALL become IDLE on the next edge.
REQ-036 A grant in the first WB cycle SHALL be honoured, giving a one-cycle WB.
REQ-037 wb_req SHALL be 0 outside WB; wb_grant outside WB SHALL be ignored.
REQ-038 Minimum latency SHALL be: accept at cycle T, fu_en at T+1, finish at T+2, redirect at T+3, wb_req at T+4; back-to-back ops SHALL be accepted no sooner than the cycle after returning to IDLE.
REQ-039 flush in EXEC, WAIT, RESOLVE or WB SHALL send the state to IDLE at the next edge and cancel any redirect, wb_req and counter update of that cycle; flush in IDLE SHALL block acceptance.
REQ-040 flush in EXEC SHALL still leave fu_en asserted in that cycle; a later stale fu_finish seen in IDLE SHALL be ignored.
REQ-041 If flush and wb_grant are both 1 in WB, flush SHALL win: no writeback is counted as done, and the state returns to IDLE.

Reset
REQ-042 rst=1 SHALL immediately force state IDLE, and clear wd_err, jump_cnt, mispred_cnt, all latched fields and the watchdog counter.
REQ-043 While rst=1, fu_en, redirect_valid and wb_req SHALL be 0, busy SHALL be 0 and issue_ready SHALL be 0.
REQ-044 Reset asserted mid-operation SHALL abandon the op without redirect or writeback.

Verification
REQ-045 Branch, predicted not-taken, cmp_res=1, pc_jump=0x100: a redirect_valid pulse with redirect_pc=0x100 at T+3; mispred_cnt=1; no wb_req.
REQ-046 JAL to rd=5, pred=1, pc_wb=0x44, wb_grant delayed 3 cycles: no redirect; wb_req held 3 cycles with wb_rd=5 and wb_data=0x44; busy falls after the grant.
REQ-047 Branch predicted taken, cmp_res=0, pc_wb=0x208: redirect_pc=0x208; jump_cnt=1 and mispred_cnt=1.
REQ-048 fu_finish held at 0: wd_err=1 after 4 WAIT cycles; state IDLE; counters unchanged; the next op is accepted normally.
REQ-049 flush asserted in WAIT, then a stale fu_finish one cycle later: no redirect or wb; issue_ready=1 the cycle after flush deasserts.
REQ-050 jump_cnt preloaded to 0xFFFF via 65535 ops, then one more op: jump_cnt stays 0xFFFF; asynchronous rst mid-WB drops wb_req immediately.
